// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async-FIFO constants and Gray/binary helpers
// Helpers work on values up to FN_W bits; callers zero-extend in and truncate out.
package fifo_pkg;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int PTR_W          = DEF_ADDR_WIDTH + 1;
    localparam int FN_W           = 32;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b = g;
        for (int i = 1; i < FN_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction
endpackage

// File: rtl/fifo_wr_ptr_ctrl_if.sv
// rtl/fifo_wr_ptr_ctrl_if.sv - write-side FIFO controller signal bundle
// ALMOST_FULL exists only when FIFO_WR_ALMOST_FULL_EN is defined.
interface fifo_wr_ptr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();
    localparam int PW = ADDR_WIDTH + 1;

    logic                  W_INC;
    logic [PW-1:0]         RD_PTR_SYNC;
    logic                  OVF_CLR;
    logic                  W_EN;
    logic [ADDR_WIDTH-1:0] W_ADDR;
    logic [PW-1:0]         WR_PTR_GRAY;
    logic                  FULL;
    logic [PW-1:0]         WR_LEVEL;
    logic                  OVERFLOW;
`ifdef FIFO_WR_ALMOST_FULL_EN
    logic                  ALMOST_FULL;
`endif

    modport master (
        output W_INC, RD_PTR_SYNC, OVF_CLR,
        input  W_EN, W_ADDR, WR_PTR_GRAY, FULL, WR_LEVEL, OVERFLOW
`ifdef FIFO_WR_ALMOST_FULL_EN
        , input ALMOST_FULL
`endif
    );

    modport slave (
        input  W_INC, RD_PTR_SYNC, OVF_CLR,
        output W_EN, W_ADDR, WR_PTR_GRAY, FULL, WR_LEVEL, OVERFLOW
`ifdef FIFO_WR_ALMOST_FULL_EN
        , output ALMOST_FULL
`endif
    );
endinterface

// File: rtl/fifo_gray_ptr.sv
// rtl/fifo_gray_ptr.sv - binary + Gray pointer pair with increment enable
// Shared by the write- and read-side controllers.
module fifo_gray_ptr
    import fifo_pkg::*;
#(
    parameter int W = PTR_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] bin_q,
    output logic [W-1:0] bin_next,
    output logic [W-1:0] gray_q,
    output logic [W-1:0] gray_next
);
    assign bin_next  = inc ? bin_q + W'(1) : bin_q;
    assign gray_next = W'(bin2gray(32'(bin_next)));

    // Gray is registered directly so the synchronizer never sees a decode glitch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= gray_next;
        end
    end
endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// rtl/fifo_wr_ptr_ctrl.sv - async FIFO write pointer, FULL/level/overflow flags
// Define FIFO_WR_ALMOST_FULL_EN to add the registered ALMOST_FULL output.
module fifo_wr_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_THRESH  = 6
) (
    input  logic               CLK,
    input  logic               RST,
    fifo_wr_ptr_ctrl_if.slave  bus
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (ADDR_WIDTH < 2) begin : g_bad_width
        $error("fifo_wr_ptr_ctrl: ADDR_WIDTH must be at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
        $error("fifo_wr_ptr_ctrl: AF_THRESH out of range");
    end

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] full_cmp;
    logic [PW-1:0] level_next;
    logic          w_en;
    logic          full_next;
    logic          ovf_event;

    assign w_en        = bus.W_INC & ~bus.FULL;
    assign bus.W_EN    = w_en;
    assign bus.W_ADDR  = ADDR_WIDTH'(wbin);

    fifo_gray_ptr #(.W(PW)) u_wptr (
        .CLK       (CLK),
        .RST       (RST),
        .inc       (w_en),
        .bin_q     (wbin),
        .bin_next  (wbin_next),
        .gray_q    (bus.WR_PTR_GRAY),
        .gray_next (wgray_next)
    );

    // Full when the writer is exactly one lap ahead: top two Gray bits inverted.
    assign full_cmp   = {~bus.RD_PTR_SYNC[PW-1 -: 2], bus.RD_PTR_SYNC[PW-3:0]};
    assign full_next  = (wgray_next == full_cmp);
    assign rd_bin     = PW'(gray2bin(32'(bus.RD_PTR_SYNC)));
    assign level_next = wbin_next - rd_bin;
    assign ovf_event  = bus.W_INC & bus.FULL;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.FULL     <= 1'b0;
            bus.WR_LEVEL <= '0;
            bus.OVERFLOW <= 1'b0;
        end else begin
            bus.FULL     <= full_next;
            bus.WR_LEVEL <= level_next;
            bus.OVERFLOW <= ovf_event | (bus.OVERFLOW & ~bus.OVF_CLR);
        end
    end

`ifdef FIFO_WR_ALMOST_FULL_EN
    localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.ALMOST_FULL <= 1'b0;
        end else begin
            bus.ALMOST_FULL <= (level_next >= AF_T);
        end
    end
`endif
endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// tb/tb_fifo_wr_ptr_ctrl.sv - scoreboard bench for fifo_wr_ptr_ctrl
// Model counts writes/reads as plain integers; the monitor checks every cycle.
module tb_fifo_wr_ptr_ctrl;
    import fifo_pkg::*;

    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int AF    = 6;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    fifo_wr_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_wr_ptr_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(AF)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        bit wen;
        int addr;
        int gray_before;
        int gray;
        bit full;
        int level;
        bit ovf;
        bit af;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    int m_wr;
    int m_rd;
    bit m_full;
    bit m_ovf;

    function automatic int gray_of(int count);
        int b;
        b = count % (2 * DEPTH);
        return b ^ (b >> 1);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_full = 0; m_ovf = 0;
    endtask

    task automatic step(bit w_inc, bit rd_adv, bit clr);
        exp_t e;
        @(posedge CLK);
        #2;
        if (rd_adv) m_rd++;
        bus.W_INC       = w_inc;
        bus.OVF_CLR     = clr;
        bus.RD_PTR_SYNC = PW'(gray_of(m_rd));
        e.wen         = w_inc && !m_full;
        e.addr        = m_wr % DEPTH;
        e.gray_before = gray_of(m_wr);
        if (e.wen) m_wr++;
        e.gray  = gray_of(m_wr);
        e.level = m_wr - m_rd;
        e.full  = (e.level == DEPTH);
        e.ovf   = (w_inc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        e.af    = (e.level >= AF);
        m_full  = e.full;
        m_ovf   = e.ovf;
        sbq.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(posedge CLK);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d entries left, required 0", sbq.size());
        end
        @(posedge CLK);
        #3;
    endtask

    // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sbq.size() > 0) begin
                e = sbq[0];
                check("w_en",   int'(bus.W_EN),   int'(e.wen));
                check("w_addr", int'(bus.W_ADDR), e.addr);
                @(posedge CLK);
                #1;
                check("wr_ptr_gray", int'(bus.WR_PTR_GRAY), e.gray);
                check("full",        int'(bus.FULL),        int'(e.full));
                check("wr_level",    int'(bus.WR_LEVEL),    e.level);
                check("overflow",    int'(bus.OVERFLOW),    int'(e.ovf));
`ifdef FIFO_WR_ALMOST_FULL_EN
                check("almost_full", int'(bus.ALMOST_FULL), int'(e.af));
`endif
                if (e.wen)
                    check("gray_one_bit", $countones(PW'(e.gray_before) ^ bus.WR_PTR_GRAY), 1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.W_INC       = 1'b0;
        bus.OVF_CLR     = 1'b0;
        bus.RD_PTR_SYNC = '0;
        model_reset();
        RST = 1'b1;
        #1;
        check("rst_gray",     int'(bus.WR_PTR_GRAY), 0);
        check("rst_full",     int'(bus.FULL),        0);
        check("rst_level",    int'(bus.WR_LEVEL),    0);
        check("rst_overflow", int'(bus.OVERFLOW),    0);
        check("rst_addr",     int'(bus.W_ADDR),      0);
`ifdef FIFO_WR_ALMOST_FULL_EN
        check("rst_almost_full", int'(bus.ALMOST_FULL), 0);
`endif
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Five writes, then an asynchronous reset between clock edges.
        repeat (5) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        drain();
        check("pre_rst_gray", int'(bus.WR_PTR_GRAY), gray_of(5));
        RST = 1'b1;
        #1;
        check("mid_rst_gray",  int'(bus.WR_PTR_GRAY), 0);
        check("mid_rst_addr",  int'(bus.W_ADDR),      0);
        check("mid_rst_level", int'(bus.WR_LEVEL),    0);
        check("mid_rst_full",  int'(bus.FULL),        0);
        check("mid_rst_wen",   int'(bus.W_EN),        0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();

        // Fill, overflow handling, first read, simultaneous read+write.
        repeat (DEPTH) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // Random traffic, write-heavy then read-heavy, wrapping the pointer many times.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 2) == 0) && (m_rd < m_wr),
                 $urandom_range(0, 7) == 0);
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 3) == 0,
                 ($urandom_range(0, 2) != 0) && (m_rd < m_wr),
                 $urandom_range(0, 7) == 0);
        step(1'b0, 1'b0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
